uart_tx_buffered: RTL and testbench
===================================

# uart_tx_buffered

Parametrised UART transmitter with an internal transmit FIFO, configurable frame format and back-to-back framing. It sits between console-mux logic and the physical TX pin. It accepts one word per strobe cycle from the mux and serialises frames LSB-first at a fixed CLK_PER_BIT bit period.

## Interface
- CLK_PER_BIT, 100: clock cycles per bit; ≥ 2.
- DATA_BITS, 8: data bits per frame; 5–9.
- PARITY, 0: 0 none, 1 odd, 2 even.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 4: entries; power of 2, ≥ 2.
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- data  in  DATA_BITS  word to enqueue.
- data_ready  in  1  push strobe; every high cycle is one push attempt.
- ready  out  1  FIFO not full; a push is accepted only when high.
- overflow  out  1  sticky; set by a push while full; cleared only by reset.
- busy  out  1  frame in progress (START through last STOP).
- done  out  1  one-cycle pulse on the last cycle of each frame's final stop bit.
- idle  out  1  FIFO empty and not busy.
- serial  out  1  TX line; idles high.

## Operation
- Reset values (asserted asynchronously): serial=1, ready=1, overflow=0, busy=0, done=0, idle=1, FIFO empty, FSM IDLE, all counters 0.
- Push: if data_ready && ready at a posedge, data is written at the tail. If data_ready && !ready, the word is dropped and overflow is set. `ready` is computed from the registered count, so a push while full is dropped even if a pop occurs in the same cycle. Push and pop in the same cycle when not full are both honoured.
- FSM states are IDLE → START → DATA → PARITY (skipped if PARITY=0) → STOP → IDLE or START.
  - IDLE: if the FIFO is non-empty, pop the head into the shift register and go to START.
  - START: serial=0 for CLK_PER_BIT cycles.
  - DATA: serial=shift[0], shifting right every CLK_PER_BIT cycles, for DATA_BITS bits.
  - PARITY: serial = XOR of the data bits for even parity, inverted for odd.
  - STOP: serial=1 for STOP_BITS×CLK_PER_BIT cycles; done pulses on the final cycle. If the FIFO is non-empty on that cycle, pop and go directly to START; otherwise go to IDLE.
- Bit timer counts 0..CLK_PER_BIT-1, width $clog2(CLK_PER_BIT). Bit counter width is $clog2(DATA_BITS+1). Both wrap to 0 on state change.
- Frame length is (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLK_PER_BIT cycles exactly.
- Reset mid-frame aborts immediately: serial returns high, the FIFO is flushed, no done pulse is produced, and overflow is cleared.

## Timing
- Latency from an accepted push into an empty, idle block to serial falling is 2 cycles: push at edge N, pop at edge N+1, serial low after edge N+2.
- Back-to-back frames have no idle gap: the next start bit begins on the cycle after the final stop-bit cycle.
- The data input is sampled only on the accepting edge; later changes do not affect a queued word.
- busy rises with the START state and falls on the cycle after done, unless a new frame follows.
- idle is registered-consistent with busy and the FIFO count, with no combinational path from data_ready.
- Outputs serial, done, busy, ready, idle and overflow are registered.

## Structure
- Package uart_pkg holds:
  - parity constants PAR_NONE, PAR_ODD, PAR_EVEN;
  - FSM state typedef tx_state_t (IDLE, START, DATA, PARITY, STOP);
  - a parity helper function.
- Sub-module sync_fifo (parameters WIDTH, DEPTH):
  - ports clk, rst_n, wr_en, wr_data, rd_en, rd_data, full, empty, count;
  - pointer wrap-around uses $clog2(DEPTH)+1-bit pointers;
  - rd_data is valid combinationally from the head.
- The top level holds the FSM, the bit/baud counters, the shift register and the parity accumulator.

## Test plan
- 8N1, CPB=100, push 0xFF once:
  - serial falls 2 cycles after the push and stays low 100 cycles;
  - serial is then high 900 cycles, with done pulsing at cycle 1000 of the frame;
  - idle=1 afterwards.
- 8E1, push 0x55: serial bits are 0, 1,0,1,0,1,0,1,0, parity 0, stop 1, each exactly 100 cycles.
- DATA_BITS=7, PARITY=1 (odd), STOP_BITS=2, push 0x41: serial bits are 0, 1,0,0,0,0,0,1, parity 1, then 200 cycles high.
- FIFO_DEPTH=4, frame in progress, push 0x01..0x05 on consecutive cycles:
  - 0x01–0x04 are accepted; ready is low during the 0x05 attempt;
  - overflow is set and 0x05 is never sent;
  - four frames follow with zero-cycle gaps, with four done pulses.
- data_ready held 3 cycles with data=0xA5: three identical 0xA5 frames back-to-back.
- rst_n low mid-DATA for 1 cycle:
  - serial is 1 immediately (asynchronously) and the FIFO is empty;
  - no done pulse occurs;
  - after release serial stays high until the next push, and overflow=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: parity modes,
// transmitter FSM states and the parity-bit helper.
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // Line level of the parity bit given the XOR of all data bits sent.
    function automatic logic parity_bit(input logic data_xor, input int unsigned mode);
        return (mode == PAR_ODD) ? ~data_xor : data_xor;
    endfunction

endpackage

// File: rtl/uart_tx_buffered_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; the head word is presented
// combinationally on rd_data.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (count == FULL_COUNT);
    assign do_wr   = wr_en & ~full;
    assign do_rd   = rd_en & ~empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// UART transmitter fed by an internal FIFO; frames are sent LSB-first and
// back-to-back whenever the FIFO still holds data at the end of a frame.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int unsigned CLK_PER_BIT = 100,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY      = 0,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 data_ready,
    output logic                 ready,
    output logic                 overflow,
    output logic                 busy,
    output logic                 done,
    output logic                 idle,
    output logic                 serial
);

    localparam int unsigned BAUD_W = $clog2(CLK_PER_BIT);
    localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    tx_state_t            state;
    logic [BAUD_W-1:0]    baud;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 par_acc;

    logic [DATA_BITS-1:0] fifo_rd_data;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CNT_W-1:0]     fifo_count;
    logic                 push;
    logic                 pop;
    logic                 bit_end;
    logic                 frame_end;
    logic                 line;

    assign ready     = ~fifo_full;
    assign push      = data_ready & ready;
    assign bit_end   = (baud == BAUD_LAST);
    assign frame_end = (state == ST_STOP) && bit_end && (bit_cnt == STOP_LAST);
    assign pop       = ~fifo_empty && ((state == ST_IDLE) || frame_end);

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data (data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_comb begin
        line = 1'b1;
        case (state)
            ST_START:  line = 1'b0;
            ST_DATA:   line = shift[0];
            ST_PARITY: line = parity_bit(par_acc, PARITY);
            default:   line = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            baud    <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            par_acc <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        shift   <= fifo_rd_data;
                        par_acc <= 1'b0;
                        baud    <= '0;
                        bit_cnt <= '0;
                        state   <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        baud  <= '0;
                        state <= ST_DATA;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        baud    <= '0;
                        shift   <= shift >> 1;
                        par_acc <= par_acc ^ shift[0];
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            state   <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        baud  <= '0;
                        state <= ST_STOP;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                ST_STOP: begin
                    // bit_cnt is reused here to count stop bits
                    if (bit_end) begin
                        baud <= '0;
                        if (bit_cnt == STOP_LAST) begin
                            bit_cnt <= '0;
                            if (pop) begin
                                shift   <= fifo_rd_data;
                                par_acc <= 1'b0;
                                state   <= ST_START;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Outputs register the current-state decode, so the pin and status
    // flags all trail the FSM by exactly one cycle and stay mutually aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            serial   <= 1'b1;
            done     <= 1'b0;
            busy     <= 1'b0;
            idle     <= 1'b1;
            overflow <= 1'b0;
        end else begin
            serial   <= line;
            done     <= frame_end;
            busy     <= (state != ST_IDLE);
            idle     <= (state == ST_IDLE) && (fifo_count == '0);
            overflow <= overflow | (data_ready & ~ready);
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: three instances (8N1, 8E1, 7O2) checked
// cycle-by-cycle against a frame model built from the bit-level frame rules.
module tb_uart_tx_buffered;

    localparam int CPB = 100;
    localparam int DBITS [3] = '{8, 8, 7};
    localparam int PARM  [3] = '{0, 2, 1};
    localparam int STOPB [3] = '{1, 1, 2};

    logic       clk;
    logic [2:0] rst_n;
    logic [2:0] dr;
    logic [2:0] rdy, ovf, bsy, dn, idl, ser;
    logic [7:0] d0, d1;
    logic [6:0] d2;

    int vectors;
    int miscompares;

    uart_tx_buffered #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
        .clk(clk), .rst_n(rst_n[0]), .data(d0), .data_ready(dr[0]), .ready(rdy[0]),
        .overflow(ovf[0]), .busy(bsy[0]), .done(dn[0]), .idle(idl[0]), .serial(ser[0]));

    uart_tx_buffered #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
        .clk(clk), .rst_n(rst_n[1]), .data(d1), .data_ready(dr[1]), .ready(rdy[1]),
        .overflow(ovf[1]), .busy(bsy[1]), .done(dn[1]), .idle(idl[1]), .serial(ser[1]));

    uart_tx_buffered #(.CLK_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u_7o2 (
        .clk(clk), .rst_n(rst_n[2]), .data(d2), .data_ready(dr[2]), .ready(rdy[2]),
        .overflow(ovf[2]), .busy(bsy[2]), .done(dn[2]), .idle(idl[2]), .serial(ser[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1);
    end

    // Expected line level of bit slot b of a frame carrying w on instance k.
    function automatic logic bit_at(input int k, input logic [7:0] w, input int b);
        int wv;
        int ones;
        wv   = int'(w) & ((1 << DBITS[k]) - 1);
        ones = $countones(wv);
        if (b == 0) return 1'b0;
        if (b <= DBITS[k]) return w[b-1];
        if (PARM[k] != 0 && b == DBITS[k] + 1)
            return (PARM[k] == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
        return 1'b1;
    endfunction

    task automatic set_data(input int k, input logic [7:0] w);
        case (k)
            0:       d0 = w;
            1:       d1 = w;
            default: d2 = w[6:0];
        endcase
    endtask

    task automatic push_word(input int k, input logic [7:0] w);
        set_data(k, w);
        dr[k] = 1'b1;
        @(posedge clk);
        #1;
        dr[k] = 1'b0;
        set_data(k, 8'($urandom));
    endtask

    task automatic wait_start(input int k);
        bit ok;
        ok = 0;
        for (int i = 0; i < 5000 && !ok; i++) begin
            @(negedge clk);
            if (ser[k] === 1'b0) ok = 1;
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL start_%0d: serial=%b after 5000 cycles, want 0", k, ser[k]);
        end
    endtask

    // Called at the negedge of the first cycle of the first start bit.
    task automatic check_frames(input int k, input string name, input logic [7:0] words[$]);
        int nb;
        int match;
        int done_hits;
        int busy_low;
        logic e;
        logic done_last;
        nb = 1 + DBITS[k] + ((PARM[k] != 0) ? 1 : 0) + STOPB[k];
        foreach (words[f]) begin
            done_hits = 0;
            busy_low  = 0;
            done_last = 1'b0;
            for (int b = 0; b < nb; b++) begin
                match = 0;
                e = bit_at(k, words[f], b);
                for (int c = 0; c < CPB; c++) begin
                    if (ser[k] === e) match++;
                    if (b == nb - 1 && c == CPB - 1) done_last = dn[k];
                    else if (dn[k] !== 1'b0) done_hits++;
                    if (bsy[k] !== 1'b1) busy_low++;
                    @(negedge clk);
                end
                vectors++;
                if (match != CPB) begin
                    miscompares++;
                    $display("FAIL %s frame%0d(0x%02h) bit%0d: %0d cycles at level %b, want %0d", name, f, words[f], b, match, e, CPB);
                end
            end
            vectors++;
            if (done_last !== 1'b1 || done_hits != 0) begin
                miscompares++;
                $display("FAIL %s frame%0d done: last=%b extra=%0d, want last=1 extra=0", name, f, done_last, done_hits);
            end
            vectors++;
            if (busy_low != 0) begin
                miscompares++;
                $display("FAIL %s frame%0d busy: low for %0d cycles, want 0", name, f, busy_low);
            end
        end
    endtask

    // Called at the negedge right after the last frame; line must stay quiet.
    task automatic check_after(input int k, input string name, input int cycles);
        int bad;
        vectors++;
        if ({ser[k], bsy[k], idl[k]} !== 3'b101) begin
            miscompares++;
            $display("FAIL %s end: serial/busy/idle=%b%b%b, want 101", name, ser[k], bsy[k], idl[k]);
        end
        bad = 0;
        for (int i = 0; i < cycles; i++) begin
            if (ser[k] !== 1'b1 || dn[k] !== 1'b0 || idl[k] !== 1'b1) bad++;
            @(negedge clk);
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL %s quiet: %0d non-idle cycles, want 0", name, bad);
        end
    endtask

    task automatic test_reset;
        rst_n = 3'b000;
        dr = 3'b000;
        d0 = '0; d1 = '0; d2 = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if ({ser[k], rdy[k], ovf[k], bsy[k], dn[k], idl[k]} !== 6'b110001) begin
                miscompares++;
                $display("FAIL reset_%0d: ser,rdy,ovf,bsy,done,idle=%b%b%b%b%b%b, want 110001",
                         k, ser[k], rdy[k], ovf[k], bsy[k], dn[k], idl[k]);
            end
        end
        rst_n = 3'b111;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if ({ser[k], rdy[k], ovf[k], bsy[k], dn[k], idl[k]} !== 6'b110001) begin
                miscompares++;
                $display("FAIL post_reset_%0d: ser,rdy,ovf,bsy,done,idle=%b%b%b%b%b%b, want 110001",
                         k, ser[k], rdy[k], ovf[k], bsy[k], dn[k], idl[k]);
            end
        end
    endtask

    task automatic test_latency_8n1;
        logic [2:0] seen;
        logic [7:0] q[$];
        push_word(0, 8'hFF);
        @(negedge clk); seen[2] = ser[0];
        @(negedge clk); seen[1] = ser[0];
        @(negedge clk); seen[0] = ser[0];
        vectors++;
        if (seen !== 3'b110) begin
            miscompares++;
            $display("FAIL latency: serial after push edges N,N+1,N+2 = %b, want 110", seen);
        end
        q = {8'hFF};
        check_frames(0, "8n1_ff", q);
        check_after(0, "8n1_ff", 200);
    endtask

    task automatic test_single(input int k, input string name, input logic [7:0] w);
        logic [7:0] q[$];
        q = {w};
        push_word(k, w);
        wait_start(k);
        check_frames(k, name, q);
        check_after(k, name, 200);
    endtask

    task automatic test_overflow;
        logic [7:0] q[$];
        q = {8'h10, 8'h01, 8'h02, 8'h03, 8'h04};
        fork
            begin
                wait_start(0);
                check_frames(0, "overflow", q);
            end
            begin
                push_word(0, 8'h10);
                repeat (3) @(posedge clk);
                #1;
                for (int i = 1; i <= 5; i++) begin
                    set_data(0, 8'(i));
                    dr[0] = 1'b1;
                    @(negedge clk);
                    vectors++;
                    if (rdy[0] !== (i <= 4)) begin
                        miscompares++;
                        $display("FAIL ovf_ready[%0d]: ready=%b, want %b", i, rdy[0], (i <= 4));
                    end
                    @(posedge clk);
                    #1;
                end
                dr[0] = 1'b0;
                vectors++;
                if (ovf[0] !== 1'b1) begin
                    miscompares++;
                    $display("FAIL ovf_flag: overflow=%b, want 1", ovf[0]);
                end
            end
        join
        check_after(0, "overflow", 1200);
    endtask

    task automatic test_back_to_back;
        logic [7:0] q[$];
        q = {8'hA5, 8'hA5, 8'hA5};
        fork
            begin
                wait_start(0);
                check_frames(0, "b2b_a5", q);
            end
            begin
                set_data(0, 8'hA5);
                dr[0] = 1'b1;
                repeat (3) @(posedge clk);
                #1;
                dr[0] = 1'b0;
                set_data(0, 8'h3C);
            end
        join
        check_after(0, "b2b_a5", 200);
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] q[$];
        push_word(0, 8'h00);
        push_word(0, 8'h00);
        wait_start(0);
        repeat (250) @(negedge clk);
        vectors++;
        if ({ser[0], bsy[0], idl[0]} !== 3'b010) begin
            miscompares++;
            $display("FAIL mid_data: serial/busy/idle=%b%b%b, want 010", ser[0], bsy[0], idl[0]);
        end
        @(posedge clk);
        #2;
        rst_n[0] = 1'b0;
        #1;
        vectors++;
        if ({ser[0], rdy[0], ovf[0], bsy[0], dn[0], idl[0]} !== 6'b110001) begin
            miscompares++;
            $display("FAIL async_reset: ser,rdy,ovf,bsy,done,idle=%b%b%b%b%b%b, want 110001",
                     ser[0], rdy[0], ovf[0], bsy[0], dn[0], idl[0]);
        end
        @(posedge clk);
        #2;
        rst_n[0] = 1'b1;
        @(negedge clk);
        check_after(0, "after_reset", 1500);
        vectors++;
        if (ovf[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL after_reset_ovf: overflow=%b, want 0", ovf[0]);
        end
        q = {8'h5A};
        push_word(0, 8'h5A);
        wait_start(0);
        check_frames(0, "recover", q);
        check_after(0, "recover", 100);
    endtask

    task automatic test_random;
        logic [7:0] q[$];
        int n;
        for (int k = 0; k < 3; k++) begin
            for (int r = 0; r < 2; r++) begin
                n = $urandom_range(1, 4);
                q = {};
                for (int i = 0; i < n; i++) q.push_back(8'($urandom));
                fork
                    begin
                        wait_start(k);
                        check_frames(k, "random", q);
                    end
                    begin
                        foreach (q[i]) begin
                            push_word(k, q[i]);
                            repeat ($urandom_range(0, 3)) @(posedge clk);
                            #1;
                        end
                    end
                join
                check_after(k, "random", 50);
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset;
        test_latency_8n1;
        test_single(1, "8e1_55", 8'h55);
        test_single(2, "7o2_41", 8'h41);
        test_overflow;
        test_back_to_back;
        test_reset_mid_frame;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
